mac_rx_filter: RTL and testbench



---
 rtl/mac_rx_filter.sv | 156 +++++++++++++++
 tb/tb_mac_rx_filter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_rx_filter.sv
// Ethernet receive filter: holds the first four words of each frame, forwards frames addressed
// to this station (or broadcast) with an accepted EtherType, and discards the rest.
// Optional per-frame pass/drop counters are enabled by defining MAC_RX_FILTER_STATS_EN.
module mac_rx_filter #(
    parameter logic [47:0] LOCAL_MAC = 48'h000A35000001,
    parameter logic [15:0] ETH_TYPE0 = 16'h0800,
    parameter logic [15:0] ETH_TYPE1 = 16'h0806
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] s_axis_tdata,
    input  logic [3:0]  s_axis_tkeep,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    output logic        s_axis_tready,
    output logic [31:0] m_axis_tdata,
    output logic [3:0]  m_axis_tkeep,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    input  logic        m_axis_tready
`ifdef MAC_RX_FILTER_STATS_EN
    ,
    output logic [15:0] pass_cnt,
    output logic [15:0] drop_cnt
`endif
);

    localparam int unsigned DW      = 32;
    localparam int unsigned KW      = 4;
    localparam int unsigned HDR_WDS = 4;
    localparam logic [47:0] BCAST   = 48'hFFFF_FFFF_FFFF;

    typedef enum logic [1:0] {HDR, REPLAY, STREAM, DROP} state_t;

    state_t          state;
    logic [DW-1:0]   hdr [HDR_WDS];
    logic [KW-1:0]   hdr_keep;
    logic            hdr_last;
    logic [1:0]      hdr_cnt;
    logic [1:0]      rp_idx;

    logic            stage_free_c;
    logic            in_acc_c;
    logic [47:0]     dst_c;
    logic [15:0]     etype_c;
    logic            hdr_pass_c;
    logic            runt3_c;

    // Header decode: word 3 is still on the input bus when the decision is made.
    always_comb begin
        stage_free_c = !m_axis_tvalid || m_axis_tready;
        s_axis_tready = 1'b0;
        case (state)
            HDR, DROP: s_axis_tready = 1'b1;
            STREAM:    s_axis_tready = stage_free_c;
            default:   s_axis_tready = 1'b0;
        endcase
        in_acc_c   = s_axis_tvalid && s_axis_tready;
        dst_c      = {hdr[0][7:0], hdr[0][15:8], hdr[0][23:16], hdr[0][31:24],
                      hdr[1][7:0], hdr[1][15:8]};
        etype_c    = {s_axis_tdata[7:0], s_axis_tdata[15:8]};
        hdr_pass_c = ((dst_c == LOCAL_MAC) || (dst_c == BCAST)) &&
                     ((etype_c == ETH_TYPE0) || (etype_c == ETH_TYPE1));
        runt3_c    = s_axis_tlast && !s_axis_tkeep[1];
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state         <= HDR;
            hdr_cnt       <= 2'd0;
            rp_idx        <= 2'd0;
            hdr_keep      <= '0;
            hdr_last      <= 1'b0;
            for (int i = 0; i < int'(HDR_WDS); i++) hdr[i] <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
        end else begin
            if (m_axis_tvalid && m_axis_tready) m_axis_tvalid <= 1'b0;
            case (state)
                HDR: begin
                    if (in_acc_c) begin
                        hdr[hdr_cnt] <= s_axis_tdata;
                        if (hdr_cnt != 2'd3) begin
                            hdr_cnt <= s_axis_tlast ? 2'd0 : 2'(hdr_cnt + 2'd1);
                        end else begin
                            hdr_cnt  <= 2'd0;
                            hdr_keep <= s_axis_tkeep;
                            hdr_last <= s_axis_tlast;
                            rp_idx   <= 2'd0;
                            if (!runt3_c && hdr_pass_c)
                                state <= REPLAY;
                            else if (!runt3_c && !s_axis_tlast)
                                state <= DROP;
                        end
                    end
                end
                REPLAY: begin
                    // Held header words only enter the output stage once it is free.
                    if (stage_free_c) begin
                        m_axis_tvalid <= 1'b1;
                        m_axis_tdata  <= hdr[rp_idx];
                        m_axis_tkeep  <= (rp_idx == 2'd3) ? hdr_keep : 4'hF;
                        m_axis_tlast  <= (rp_idx == 2'd3) && hdr_last;
                        rp_idx        <= 2'(rp_idx + 2'd1);
                        if (rp_idx == 2'd3) state <= hdr_last ? HDR : STREAM;
                    end
                end
                STREAM: begin
                    if (in_acc_c) begin
                        m_axis_tvalid <= 1'b1;
                        m_axis_tdata  <= s_axis_tdata;
                        m_axis_tkeep  <= s_axis_tkeep;
                        m_axis_tlast  <= s_axis_tlast;
                        if (s_axis_tlast) state <= HDR;
                    end
                end
                DROP: begin
                    if (in_acc_c && s_axis_tlast) state <= HDR;
                end
                default: state <= HDR;
            endcase
        end
    end

`ifdef MAC_RX_FILTER_STATS_EN
    logic pass_evt_c;
    logic drop_evt_c;

    // One event per frame: a verdict at word 3 or an early tlast.
    always_comb begin
        pass_evt_c = 1'b0;
        drop_evt_c = 1'b0;
        if (state == HDR && in_acc_c) begin
            if (hdr_cnt != 2'd3) begin
                drop_evt_c = s_axis_tlast;
            end else begin
                pass_evt_c = !runt3_c && hdr_pass_c;
                drop_evt_c = runt3_c || !hdr_pass_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            pass_cnt <= 16'd0;
            drop_cnt <= 16'd0;
        end else begin
            if (pass_evt_c && pass_cnt != 16'hFFFF) pass_cnt <= 16'(pass_cnt + 16'd1);
            if (drop_evt_c && drop_cnt != 16'hFFFF) drop_cnt <= 16'(drop_cnt + 16'd1);
        end
    end
`endif

endmodule

// File: tb/tb_mac_rx_filter.sv
// Scoreboard bench for mac_rx_filter: directed frames, expected words queued at issue time.
`timescale 1ns/1ps
module tb_mac_rx_filter;

    localparam logic [47:0] LOCAL = 48'h000A35000001;
    localparam logic [47:0] BCAST = 48'hFFFFFFFFFFFF;
    localparam logic [47:0] OTHER = 48'h000A35000002;

    logic        clk;
    logic        rstn;
    logic [31:0] s_axis_tdata;
    logic [3:0]  s_axis_tkeep;
    logic        s_axis_tvalid;
    logic        s_axis_tlast;
    logic        s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tkeep;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tready;
`ifdef MAC_RX_FILTER_STATS_EN
    logic [15:0] pass_cnt;
    logic [15:0] drop_cnt;
`endif

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } beat_t;

    beat_t q[$];
    int    vectors = 0;
    int    miscompares = 0;
    int    cyc = 0;
    int    acc_cyc = 0;
    int    mode = 0;
    int    exp_pass = 0;
    int    exp_drop = 0;
    bit    mon_en = 1;
    bit    lat_armed = 0;
    bit    body = 0;
    bit    held_v = 0;
    logic [37:0] held = '0;
    logic [3:0]  pat = 4'b1001;
    int    ph = 0;

    mac_rx_filter dut (
        .clk           (clk),
        .rstn          (rstn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready)
`ifdef MAC_RX_FILTER_STATS_EN
        ,
        .pass_cnt      (pass_cnt),
        .drop_cnt      (drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Downstream ready: steady 1, or the repeating 1,0,0,1 pattern.
    always @(posedge clk) begin
        #1;
        if (mode == 0) begin
            m_axis_tready = 1'b1;
        end else begin
            m_axis_tready = pat[ph];
            ph = (ph + 1) % 4;
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every output handshake and checks hold/backpressure rules.
    always @(negedge clk) begin
        beat_t e;
        if (!rstn) begin
            held_v = 0;
        end else begin
            if (held_v)
                check("out_hold", {26'd0, m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata},
                      {26'd0, held});
            if (lat_armed && m_axis_tvalid) begin
                check("first_out_latency", 64'(cyc - acc_cyc), 64'd1);
                lat_armed = 0;
            end
            if (body && m_axis_tvalid && !m_axis_tready)
                check("s_ready_backpressure", {63'd0, s_axis_tready}, 64'd0);
            if (m_axis_tvalid && m_axis_tready && mon_en) begin
                if (q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_out: got word %h keep %h last %b with nothing expected",
                             m_axis_tdata, m_axis_tkeep, m_axis_tlast);
                end else begin
                    e = q.pop_front();
                    check("out_word", {27'd0, m_axis_tlast, m_axis_tkeep, m_axis_tdata},
                          {27'd0, e.l, e.k, e.d});
                end
            end
            held_v = m_axis_tvalid && !m_axis_tready;
            held   = {m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata};
        end
    end

    // Builds a frame of len bytes, queues it if it should be forwarded, sends the first nsend words.
    task automatic send_frame(input int len, input logic [47:0] dst, input logic [15:0] et,
                              input bit pass, input bit push, input int nsend,
                              input bit gap, input bit lat);
        logic [7:0]  fb [128];
        logic [31:0] wd [32];
        logic [3:0]  wk [32];
        int nw;
        int t;
        beat_t b;
        nw = (len + 3) / 4;
        for (int i = 0; i < len; i++) begin
            if (i < 6)       fb[i] = dst[47 - 8*i -: 8];
            else if (i < 12) fb[i] = 8'(8'hA0 + i);
            else if (i == 12) fb[i] = et[15:8];
            else if (i == 13) fb[i] = et[7:0];
            else             fb[i] = 8'(i * 7 + len);
        end
        for (int w = 0; w < nw; w++) begin
            for (int j = 0; j < 4; j++) begin
                if (4*w + j < len) begin
                    wd[w][8*j +: 8] = fb[4*w + j];
                    wk[w][j] = 1'b1;
                end else begin
                    wd[w][8*j +: 8] = 8'h00;
                    wk[w][j] = 1'b0;
                end
            end
            if (pass && push) begin
                b.d = wd[w]; b.k = wk[w]; b.l = (w == nw - 1);
                q.push_back(b);
            end
        end
        if (pass) exp_pass++; else exp_drop++;
        for (int w = 0; w < nsend; w++) begin
            if (gap && w == 2) begin
                s_axis_tvalid = 1'b0;
                repeat (2) @(posedge clk);
                #1;
            end
            s_axis_tdata  = wd[w];
            s_axis_tkeep  = wk[w];
            s_axis_tlast  = (w == nw - 1);
            s_axis_tvalid = 1'b1;
            t = 0;
            forever begin
                @(negedge clk);
                if (w < 4 && t == 0) check("hdr_s_ready", {63'd0, s_axis_tready}, 64'd1);
                if (s_axis_tready) break;
                t++;
                if (t > 200) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL accept_timeout: word %0d of %0d-byte frame never accepted", w, len);
                    s_axis_tvalid = 1'b0;
                    return;
                end
            end
            @(posedge clk);
            #1;
            if (w == 3) begin
                if (lat) begin acc_cyc = cyc; lat_armed = 1; end
                body = pass && (nw > 4);
            end
            if (w == nw - 1) body = 0;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        if (pass && nw == 4) begin
            repeat (8) @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (q.size() != 0 && t < 2000) begin
            @(posedge clk);
            t++;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata = '0;
        s_axis_tkeep = '0;
        s_axis_tlast = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        check("rst_m_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
        check("rst_m_tdata", {32'd0, m_axis_tdata}, 64'd0);
        check("rst_m_tkeep", {60'd0, m_axis_tkeep}, 64'd0);
        check("rst_m_tlast", {63'd0, m_axis_tlast}, 64'd0);
        check("rst_s_tready", {63'd0, s_axis_tready}, 64'd1);
        @(posedge clk);
        #1;

        // Unicast 64 bytes with latency check, then broadcast ARP of 61 bytes
        send_frame(64, LOCAL, 16'h0800, 1, 1, 16, 0, 1);
        send_frame(61, BCAST, 16'h0806, 1, 1, 16, 0, 0);
        // Wrong station address then a match
        send_frame(60, OTHER, 16'h0800, 0, 1, 15, 0, 0);
        send_frame(48, LOCAL, 16'h0800, 1, 1, 12, 0, 0);
        // Runt of 3 words, then a valid frame with an idle gap in its header
        send_frame(10, LOCAL, 16'h0800, 0, 1, 3, 0, 0);
        send_frame(52, BCAST, 16'h0800, 1, 1, 13, 1, 0);
        // Word-3 boundaries: rejected EtherType, 13-byte runt, 16- and 14-byte passes
        send_frame(16, LOCAL, 16'h86DD, 0, 1, 4, 0, 0);
        send_frame(13, LOCAL, 16'h0800, 0, 1, 4, 0, 0);
        send_frame(16, LOCAL, 16'h0806, 1, 1, 4, 0, 0);
        send_frame(14, BCAST, 16'h0800, 1, 1, 4, 0, 0);
        send_frame(20, LOCAL, 16'h0800, 1, 1, 5, 0, 0);
        wait_drain();

        // Downstream backpressure 1,0,0,1
        mode = 1;
        send_frame(40, LOCAL, 16'h0800, 1, 1, 10, 0, 0);
        send_frame(64, BCAST, 16'h0806, 1, 1, 16, 0, 0);
        send_frame(24, OTHER, 16'h0806, 0, 1, 6, 0, 0);
        send_frame(36, LOCAL, 16'h0806, 1, 1, 9, 0, 0);
        wait_drain();
        mode = 0;
        repeat (2) @(posedge clk);
        #1;

`ifdef MAC_RX_FILTER_STATS_EN
        check("pass_cnt", {48'd0, pass_cnt}, 64'(exp_pass));
        check("drop_cnt", {48'd0, drop_cnt}, 64'(exp_drop));
`endif

        // Reset for one cycle while streaming payload
        mon_en = 0;
        send_frame(64, LOCAL, 16'h0800, 1, 0, 8, 0, 0);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        body = 0;
        exp_pass = 0;
        exp_drop = 0;
        @(negedge clk);
        check("post_rst_m_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
        check("post_rst_s_tready", {63'd0, s_axis_tready}, 64'd1);
        check("post_rst_m_tdata", {32'd0, m_axis_tdata}, 64'd0);
`ifdef MAC_RX_FILTER_STATS_EN
        check("post_rst_pass_cnt", {48'd0, pass_cnt}, 64'd0);
        check("post_rst_drop_cnt", {48'd0, drop_cnt}, 64'd0);
`endif
        mon_en = 1;
        @(posedge clk);
        #1;
        send_frame(64, BCAST, 16'h0800, 1, 1, 16, 0, 0);
        wait_drain();
        check("queue_drained", 64'(q.size()), 64'd0);
`ifdef MAC_RX_FILTER_STATS_EN
        check("final_pass_cnt", {48'd0, pass_cnt}, 64'(exp_pass));
        check("final_drop_cnt", {48'd0, drop_cnt}, 64'(exp_drop));
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
